// File: rtl/cpu_datapath_p.sv
// Parametrised accumulator datapath: AR/PC/DR/TR/IR/AC/Z, general register file,
// muxed internal bus, ALU and a memory handshake FSM with wait states and timeout.
module cpu_datapath_p #(
   parameter int              DW      = 8,
   parameter int              AW      = 16,
   parameter int              NREG    = 4,
   parameter logic [AW-1:0]   PC_RST  = '0,
   parameter int              TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [2:0]               bus_sel,
   input  logic                     ar_load,
   input  logic                     ar_inc,
   input  logic                     pc_load,
   input  logic                     pc_inc,
   input  logic                     dr_load,
   input  logic                     tr_load,
   input  logic                     ir_load,
   input  logic                     r_load,
   input  logic                     ac_load,
   input  logic [$clog2(NREG)-1:0]  r_sel,
   input  logic [3:0]               alus,
   input  logic                     mem_rd,
   input  logic                     mem_wr,
   input  logic                     mem_ack,
   input  logic [DW-1:0]            mem_rdata,
   output logic [AW-1:0]            mem_addr,
   output logic [DW-1:0]            mem_wdata,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic                     busy,
   output logic                     mem_done,
   output logic                     mem_err,
   output logic [AW-1:0]            dbus,
   output logic [DW-1:0]            ir,
   output logic [DW-1:0]            ac,
   output logic                     z
);

   localparam int CW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   logic [AW-1:0] ar;
   logic [AW-1:0] pc;
   logic [DW-1:0] dr;
   logic [DW-1:0] tr;
   logic [DW-1:0] rf [NREG];
   logic [DW-1:0] alu_b;
   logic [DW-1:0] alu_res;
   logic [1:0]    state;
   logic [CW-1:0] wcnt;
   logic          we_r;
   logic          access;
   logic          rd_ack;

   always_comb begin
      dbus = '0;
      case (bus_sel)
         3'd1:    dbus = pc;
         3'd2:    dbus = AW'(dr);
         3'd3:    dbus = AW'({dr, tr});
         3'd4:    dbus = AW'(ac);
         3'd5:    dbus = AW'(rf[r_sel]);
         3'd6:    dbus = AW'(tr);
         default: dbus = '0;
      endcase
   end

   assign alu_b = dbus[DW-1:0];

   always_comb begin
      alu_res = ac;
      case (alus)
         4'd0:    alu_res = alu_b;
         4'd1:    alu_res = ac + alu_b;
         4'd2:    alu_res = ac - alu_b;
         4'd3:    alu_res = ac & alu_b;
         4'd4:    alu_res = ac | alu_b;
         4'd5:    alu_res = ac ^ alu_b;
         4'd6:    alu_res = ~ac;
         4'd7:    alu_res = ac + 1'b1;
         4'd8:    alu_res = '0;
         4'd9:    alu_res = {ac[DW-2:0], 1'b0};
         4'd10:   alu_res = {1'b0, ac[DW-1:1]};
         default: alu_res = ac;
      endcase
   end

   assign access   = (state == ACCESS);
   assign rd_ack   = access & mem_ack & ~we_r;
   assign mem_req  = access;
   assign busy     = access;
   assign mem_we   = access & we_r;
   assign mem_done = (state == DONE);
   assign mem_addr = ar;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wcnt      <= '0;
         we_r      <= 1'b0;
         mem_wdata <= '0;
         mem_err   <= 1'b0;
      end else begin
         // conflicting or out-of-turn start pulses only flag an error
         if ((mem_rd & mem_wr) || ((mem_rd | mem_wr) && state != IDLE))
            mem_err <= 1'b1;
         case (state)
            IDLE: begin
               if (mem_rd ^ mem_wr) begin
                  state <= ACCESS;
                  we_r  <= mem_wr;
                  wcnt  <= '0;
                  if (mem_wr)
                     mem_wdata <= dbus[DW-1:0];
               end
            end
            ACCESS: begin
               if (mem_ack) begin
                  state <= DONE;
               end else if (wcnt == CW'(TIMEOUT - 1)) begin
                  state   <= DONE;
                  mem_err <= 1'b1;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ar <= '0;
         pc <= PC_RST;
         dr <= '0;
         tr <= '0;
         ir <= '0;
         ac <= '0;
         z  <= 1'b0;
         for (int unsigned i = 0; i < NREG; i++)
            rf[i] <= '0;
      end else begin
         // AR is frozen while the memory is addressed
         if (!access) begin
            if (ar_load)
               ar <= dbus;
            else if (ar_inc)
               ar <= ar + 1'b1;
         end
         if (pc_load)
            pc <= dbus;
         else if (pc_inc)
            pc <= pc + 1'b1;
         if (rd_ack)
            dr <= mem_rdata;
         else if (dr_load)
            dr <= dbus[DW-1:0];
         if (tr_load)
            tr <= dbus[DW-1:0];
         if (ir_load)
            ir <= dr;
         if (r_load)
            rf[r_sel] <= dbus[DW-1:0];
         if (ac_load) begin
            ac <= alu_res;
            z  <= (alu_res == '0);
         end
      end
   end

endmodule

// File: tb/tb_cpu_datapath_p.sv
// Directed bench for cpu_datapath_p: ALU vector table plus hand-written
// sequences for bus, register, and memory handshake corner cases.
module tb_cpu_datapath_p;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  bus_sel = '0;
   logic        ar_load = 0, ar_inc = 0, pc_load = 0, pc_inc = 0;
   logic        dr_load = 0, tr_load = 0, ir_load = 0, r_load = 0, ac_load = 0;
   logic [1:0]  r_sel = '0;
   logic [3:0]  alus = '0;
   logic        mem_rd = 0, mem_wr = 0, mem_ack = 0;
   logic [7:0]  mem_rdata = '0;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_req, mem_we, busy, mem_done, mem_err;
   logic [15:0] dbus;
   logic [7:0]  ir, ac;
   logic        z;

   int errors = 0;
   int checks = 0;

   cpu_datapath_p #(
      .DW(8), .AW(16), .NREG(4), .PC_RST(16'h0100), .TIMEOUT(15)
   ) dut (
      .clk(clk), .rst(rst), .bus_sel(bus_sel),
      .ar_load(ar_load), .ar_inc(ar_inc), .pc_load(pc_load), .pc_inc(pc_inc),
      .dr_load(dr_load), .tr_load(tr_load), .ir_load(ir_load), .r_load(r_load),
      .ac_load(ac_load), .r_sel(r_sel), .alus(alus),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
      .busy(busy), .mem_done(mem_done), .mem_err(mem_err), .dbus(dbus),
      .ir(ir), .ac(ac), .z(z)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] dr;
      logic [3:0] op;
      logic       ld;
      logic [7:0] exp_ac;
      logic       exp_z;
   } alu_vec_t;

   alu_vec_t tbl[17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // zero-wait read that deposits val into DR
   task automatic mem_read(input logic [7:0] val);
      mem_rd = 1'b1;
      tick();
      mem_rd    = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = val;
      tick();
      mem_ack = 1'b0;
      tick();
   endtask

   initial begin
      int reqcnt, donecnt, wecnt;

      tbl[0]  = '{8'h00, 4'd6,  1'b1, 8'hFF, 1'b0};
      tbl[1]  = '{8'h01, 4'd1,  1'b1, 8'h00, 1'b1};
      tbl[2]  = '{8'h01, 4'd7,  1'b1, 8'h01, 1'b0};
      tbl[3]  = '{8'h3C, 4'd0,  1'b1, 8'h3C, 1'b0};
      tbl[4]  = '{8'h0F, 4'd3,  1'b1, 8'h0C, 1'b0};
      tbl[5]  = '{8'hF0, 4'd4,  1'b1, 8'hFC, 1'b0};
      tbl[6]  = '{8'hFF, 4'd5,  1'b1, 8'h03, 1'b0};
      tbl[7]  = '{8'h05, 4'd2,  1'b1, 8'hFE, 1'b0};
      tbl[8]  = '{8'h00, 4'd9,  1'b1, 8'hFC, 1'b0};
      tbl[9]  = '{8'h00, 4'd10, 1'b1, 8'h7E, 1'b0};
      tbl[10] = '{8'h77, 4'd8,  1'b1, 8'h00, 1'b1};
      tbl[11] = '{8'h00, 4'd7,  1'b1, 8'h01, 1'b0};
      tbl[12] = '{8'h99, 4'd12, 1'b1, 8'h01, 1'b0};
      tbl[13] = '{8'h00, 4'd3,  1'b1, 8'h00, 1'b1};
      tbl[14] = '{8'h00, 4'd7,  1'b0, 8'h00, 1'b1};
      tbl[15] = '{8'h00, 4'd6,  1'b1, 8'hFF, 1'b0};
      tbl[16] = '{8'h42, 4'd15, 1'b1, 8'hFF, 1'b0};

      do_reset();
      chk("rst_addr",  mem_addr,  16'h0000);
      chk("rst_wdata", mem_wdata, 8'h00);
      chk("rst_req",   mem_req,   1'b0);
      chk("rst_we",    mem_we,    1'b0);
      chk("rst_busy",  busy,      1'b0);
      chk("rst_done",  mem_done,  1'b0);
      chk("rst_err",   mem_err,   1'b0);
      chk("rst_ir",    ir,        8'h00);
      chk("rst_ac",    ac,        8'h00);
      chk("rst_z",     z,         1'b0);
      chk("rst_bus0",  dbus,      16'h0000);
      bus_sel = 3'd1; #1;
      chk("rst_pc",    dbus,      16'h0100);

      for (int i = 0; i < 17; i++) begin
         mem_read(tbl[i].dr);
         bus_sel = 3'd2;
         alus    = tbl[i].op;
         ac_load = tbl[i].ld;
         #1;
         chk($sformatf("alu_bus%0d", i), dbus, {8'h00, tbl[i].dr});
         tick();
         ac_load = 1'b0;
         chk($sformatf("alu_ac%0d", i), ac, tbl[i].exp_ac);
         chk($sformatf("alu_z%0d", i),  z,  tbl[i].exp_z);
      end

      // PC load, priority and wrap
      mem_read(8'hFF);
      bus_sel = 3'd2; tr_load = 1'b1; tick(); tr_load = 1'b0;
      bus_sel = 3'd3; pc_load = 1'b1; pc_inc = 1'b1; tick(); pc_load = 1'b0; pc_inc = 1'b0;
      bus_sel = 3'd1; #1;
      chk("pc_ffff", dbus, 16'hFFFF);
      pc_inc = 1'b1; tick(); pc_inc = 1'b0;
      chk("pc_wrap", dbus, 16'h0000);

      // AR from {DR,TR}, load priority over increment
      mem_read(8'h34);
      bus_sel = 3'd2; tr_load = 1'b1; tick(); tr_load = 1'b0;
      mem_read(8'h12);
      bus_sel = 3'd3; #1;
      chk("bus_drtr", dbus, 16'h1234);
      ar_load = 1'b1; tick(); ar_load = 1'b0;
      chk("ar_1234", mem_addr, 16'h1234);
      bus_sel = 3'd2; ar_load = 1'b1; ar_inc = 1'b1; tick(); ar_load = 1'b0;
      chk("ar_ld_pri", mem_addr, 16'h0012);
      tick(); ar_inc = 1'b0;
      chk("ar_inc", mem_addr, 16'h0013);

      // read with three wait cycles, ar_inc held during the access
      mem_read(8'h40);
      bus_sel = 3'd2; ar_load = 1'b1; tick(); ar_load = 1'b0;
      chk("ar_0040", mem_addr, 16'h0040);
      mem_rd = 1'b1; tick(); mem_rd = 1'b0;
      reqcnt = 0; donecnt = 0; wecnt = 0;
      mem_rdata = 8'hA5;
      for (int c = 0; c < 20; c++) begin
         if (mem_req) reqcnt++;
         if (mem_done) donecnt++;
         if (mem_we) wecnt++;
         ar_inc  = mem_req;
         mem_ack = mem_req && (reqcnt == 4);
         tick();
         if (!mem_req) ar_inc = 1'b0;
         mem_ack = 1'b0;
      end
      ar_inc = 1'b0;
      chk("rd_req_cycles", reqcnt, 4);
      chk("rd_done_pulses", donecnt, 1);
      chk("rd_we", wecnt, 0);
      chk("rd_ar_frozen", mem_addr, 16'h0040);
      chk("rd_err", mem_err, 1'b0);
      bus_sel = 3'd2; #1;
      chk("rd_dr", dbus, 16'h00A5);

      bus_sel = 3'd0; ir_load = 1'b1; tick(); ir_load = 1'b0;
      chk("ir_from_dr", ir, 8'hA5);

      // register file
      mem_read(8'h5C);
      bus_sel = 3'd2; r_sel = 2'd2; r_load = 1'b1; tick(); r_load = 1'b0;
      bus_sel = 3'd5; #1;
      chk("r2", dbus, 16'h005C);
      r_sel = 2'd1; #1;
      chk("r1", dbus, 16'h0000);

      // start pulse while busy
      mem_rd = 1'b1; tick(); mem_rd = 1'b0;
      mem_wr = 1'b1; tick(); mem_wr = 1'b0;
      chk("busy_start_req", mem_req, 1'b1);
      chk("busy_start_err", mem_err, 1'b1);
      mem_ack = 1'b1; tick(); mem_ack = 1'b0;
      chk("busy_start_done", mem_done, 1'b1);
      tick();

      // reset clears error; simultaneous rd+wr
      do_reset();
      bus_sel = 3'd1; #1;
      chk("rst2_err", mem_err, 1'b0);
      chk("rst2_pc", dbus, 16'h0100);
      mem_rd = 1'b1; mem_wr = 1'b1; tick(); mem_rd = 1'b0; mem_wr = 1'b0;
      chk("both_req", mem_req, 1'b0);
      chk("both_err", mem_err, 1'b1);
      tick();
      chk("both_req2", mem_req, 1'b0);

      // write timeout
      do_reset();
      mem_read(8'h5A);
      bus_sel = 3'd2; mem_wr = 1'b1; tick(); mem_wr = 1'b0;
      bus_sel = 3'd0;
      reqcnt = 0; donecnt = 0; wecnt = 0;
      for (int c = 0; c < 40; c++) begin
         if (mem_req) reqcnt++;
         if (mem_done) donecnt++;
         if (mem_req && mem_we) wecnt++;
         tick();
      end
      chk("to_req_cycles", reqcnt, 15);
      chk("to_we_cycles", wecnt, 15);
      chk("to_done_pulses", donecnt, 1);
      chk("to_err", mem_err, 1'b1);
      chk("to_wdata", mem_wdata, 8'h5A);
      bus_sel = 3'd2; #1;
      chk("to_dr_kept", dbus, 16'h005A);
      tick(); tick();
      chk("to_err_sticky", mem_err, 1'b1);

      // reset in the middle of a read
      do_reset();
      mem_rd = 1'b1; tick(); mem_rd = 1'b0;
      tick();
      chk("mid_req_before", mem_req, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("mid_req_after", mem_req, 1'b0);
      chk("mid_busy_after", busy, 1'b0);
      tick();
      rst = 1'b0;
      donecnt = 0;
      for (int c = 0; c < 5; c++) begin
         if (mem_done) donecnt++;
         tick();
      end
      chk("mid_no_done", donecnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
